// File: rtl/mmio_memory_map_v2.sv
// ---------------------------------------------------------------------------
// mmio_memory_map_v2
//
// Dual-port memory map sitting between the core's two data ports and an
// on-chip SRAM plus a window of MMIO register slots.
//
// Slot layout (slot i lives at REG_BASE + i*REG_STRIDE):
//   slots 0 .. NUM_CFG-1                     plain R/W config registers
//   slots NUM_CFG .. NUM_CFG+NUM_ACCEL-1     accelerator ctrl/status CS_k
// CS_k bits: [0] BUSY (RO), [1] DONE (sticky, W1C), [2] IRQ_EN (R/W, only
// stored when MMIO_IRQ_EN is defined), other bits read 0.
//
// Any address that is not an exact slot address goes to the SRAM, which is
// word-indexed by the low SRAM_AW address bits.
//
// Optional feature macro: MMIO_IRQ_EN (adds o_irq and the IRQ_EN bit).
//
// Ports:
//   i_clk              clock, all logic on posedge
//   i_rst              synchronous active-high reset
//   i_addr_a/b         port A/B address
//   i_data_a/b         port A/B write data
//   i_we_a/b           port A/B write enable
//   o_q_a/b            port A/B read data, 1 cycle after address
//   o_cfg_regs         config slots, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_accel_start      1-cycle start pulse per accelerator
//   i_accel_done       1-cycle done pulse per accelerator
//   o_irq              (MMIO_IRQ_EN only) OR of DONE & IRQ_EN, registered
// ---------------------------------------------------------------------------
module mmio_memory_map_v2 #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_CFG    = 11,
    parameter int                    NUM_ACCEL  = 3,
    parameter logic [ADDR_WIDTH-1:0] REG_BASE   = 'h0,
    parameter logic [ADDR_WIDTH-1:0] REG_STRIDE = 'h100,
    parameter int                    SRAM_AW    = 12
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [ADDR_WIDTH-1:0]           i_addr_a,
    input  logic [ADDR_WIDTH-1:0]           i_addr_b,
    input  logic [DATA_WIDTH-1:0]           i_data_a,
    input  logic [DATA_WIDTH-1:0]           i_data_b,
    input  logic                            i_we_a,
    input  logic                            i_we_b,
    output logic signed [DATA_WIDTH-1:0]    o_q_a,
    output logic signed [DATA_WIDTH-1:0]    o_q_b,
    output logic [NUM_CFG*DATA_WIDTH-1:0]   o_cfg_regs,
    output logic [NUM_ACCEL-1:0]            o_accel_start,
    input  logic [NUM_ACCEL-1:0]            i_accel_done
`ifdef MMIO_IRQ_EN
    ,
    output logic                            o_irq
`endif
);

    localparam int                    NUM_SLOTS  = NUM_CFG + NUM_ACCEL;
    localparam int                    SRAM_DEPTH = 2 ** SRAM_AW;
    localparam logic [ADDR_WIDTH-1:0] SLOTS_A    = ADDR_WIDTH'(NUM_SLOTS);

    // ---------------- decode ----------------
    logic [ADDR_WIDTH-1:0] w_off_a, w_off_b;
    logic [ADDR_WIDTH-1:0] w_idx_a, w_idx_b;
    logic                  w_hit_a, w_hit_b;
    logic                  w_wr_a, w_wr_b;
    logic                  w_sram_we_a, w_sram_we_b;

    always_comb begin
        w_off_a = i_addr_a - REG_BASE;
        w_off_b = i_addr_b - REG_BASE;
        w_idx_a = w_off_a / REG_STRIDE;
        w_idx_b = w_off_b / REG_STRIDE;
        w_hit_a = (i_addr_a >= REG_BASE) && ((w_off_a % REG_STRIDE) == '0) && (w_idx_a < SLOTS_A);
        w_hit_b = (i_addr_b >= REG_BASE) && ((w_off_b % REG_STRIDE) == '0) && (w_idx_b < SLOTS_A);
        w_wr_a      = i_we_a & w_hit_a;
        w_wr_b      = i_we_b & w_hit_b;
        // each port gates its own SRAM write; a register hit never leaks into SRAM
        w_sram_we_a = i_we_a & ~w_hit_a;
        w_sram_we_b = i_we_b & ~w_hit_b;
    end

    // ---------------- SRAM (not reset, read-before-write, A wins on collision) ----------------
    logic [DATA_WIDTH-1:0] r_mem [0:SRAM_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_sram_q_a, r_sram_q_b;

    always_ff @(posedge i_clk) begin
        if (w_sram_we_b) r_mem[i_addr_b[SRAM_AW-1:0]] <= i_data_b;
        if (w_sram_we_a) r_mem[i_addr_a[SRAM_AW-1:0]] <= i_data_a;
        r_sram_q_a <= r_mem[i_addr_a[SRAM_AW-1:0]];
        r_sram_q_b <= r_mem[i_addr_b[SRAM_AW-1:0]];
    end

    // ---------------- register state ----------------
    logic [DATA_WIDTH-1:0] r_cfg [0:NUM_CFG-1];
    logic [NUM_ACCEL-1:0]  r_busy;
    logic [NUM_ACCEL-1:0]  r_done;
    logic [NUM_ACCEL-1:0]  r_start;
    logic [NUM_ACCEL-1:0]  w_irq_en;

    // one effective write per CS slot; port A takes the whole write on a clash
    logic [NUM_ACCEL-1:0]  w_cs_wr;
    logic [2:0]            w_cs_d [0:NUM_ACCEL-1];
    logic [NUM_ACCEL-1:0]  w_go;

    always_comb begin
        for (int k = 0; k < NUM_ACCEL; k++) begin
            w_cs_wr[k] = 1'b0;
            w_cs_d[k]  = 3'b000;
            if (w_wr_a && (w_idx_a == ADDR_WIDTH'(NUM_CFG + k))) begin
                w_cs_wr[k] = 1'b1;
                w_cs_d[k]  = i_data_a[2:0];
            end else if (w_wr_b && (w_idx_b == ADDR_WIDTH'(NUM_CFG + k))) begin
                w_cs_wr[k] = 1'b1;
                w_cs_d[k]  = i_data_b[2:0];
            end
            w_go[k] = w_cs_wr[k] & w_cs_d[k][0] & ~r_busy[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= '0;
            r_busy  <= '0;
            r_done  <= '0;
            r_start <= '0;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (w_wr_a && (w_idx_a == ADDR_WIDTH'(i)))
                    r_cfg[i] <= i_data_a;
                else if (w_wr_b && (w_idx_b == ADDR_WIDTH'(i)))
                    r_cfg[i] <= i_data_b;
            end
            for (int k = 0; k < NUM_ACCEL; k++) begin
                // a done arriving with the start write cancels the start outright
                r_start[k] <= w_go[k] & ~i_accel_done[k];
                if (i_accel_done[k])
                    r_busy[k] <= 1'b0;
                else if (w_go[k])
                    r_busy[k] <= 1'b1;
                // set beats the write-1-to-clear
                if (i_accel_done[k])
                    r_done[k] <= 1'b1;
                else if (w_cs_wr[k] && w_cs_d[k][1])
                    r_done[k] <= 1'b0;
            end
        end
    end

`ifdef MMIO_IRQ_EN
    logic [NUM_ACCEL-1:0] r_irq_en;
    logic                 r_irq;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_ACCEL; k++)
                if (w_cs_wr[k]) r_irq_en[k] <= w_cs_d[k][2];
            r_irq <= |(r_done & r_irq_en);
        end
    end

    assign w_irq_en = r_irq_en;
    assign o_irq    = r_irq;
`else
    logic w_unused_irq_en;
    always_comb begin
        w_unused_irq_en = 1'b0;
        for (int k = 0; k < NUM_ACCEL; k++)
            w_unused_irq_en = w_unused_irq_en ^ w_cs_d[k][2];
    end
    assign w_irq_en = '0;
`endif

    // ---------------- MMIO read mux (old values on same-cycle write) ----------------
    logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (w_idx_a == ADDR_WIDTH'(i)) w_rd_a = r_cfg[i];
            if (w_idx_b == ADDR_WIDTH'(i)) w_rd_b = r_cfg[i];
        end
        for (int k = 0; k < NUM_ACCEL; k++) begin
            if (w_idx_a == ADDR_WIDTH'(NUM_CFG + k))
                w_rd_a = {{(DATA_WIDTH-3){1'b0}}, w_irq_en[k], r_done[k], r_busy[k]};
            if (w_idx_b == ADDR_WIDTH'(NUM_CFG + k))
                w_rd_b = {{(DATA_WIDTH-3){1'b0}}, w_irq_en[k], r_done[k], r_busy[k]};
        end
    end

    logic                  r_hit_a, r_hit_b;
    logic [DATA_WIDTH-1:0] r_mmio_q_a, r_mmio_q_b;

    // reset steers the output mux onto the (zeroed) MMIO path so q reads 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit_a    <= 1'b1;
            r_hit_b    <= 1'b1;
            r_mmio_q_a <= '0;
            r_mmio_q_b <= '0;
        end else begin
            r_hit_a    <= w_hit_a;
            r_hit_b    <= w_hit_b;
            r_mmio_q_a <= w_rd_a;
            r_mmio_q_b <= w_rd_b;
        end
    end

    assign o_q_a         = r_hit_a ? r_mmio_q_a : r_sram_q_a;
    assign o_q_b         = r_hit_b ? r_mmio_q_b : r_sram_q_b;
    assign o_accel_start = r_start;

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign o_cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_cfg[g];
    end

endmodule
